// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ps2_pkg
// Purpose  : Set-2 scancode constants, decoder state encoding, event layout.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

    localparam int EV_W   = 10;
    localparam int EV_BRK = 9;
    localparam int EV_EXT = 8;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    localparam logic [7:0] FAKE_LSHIFT = 8'h12;
    localparam logic [7:0] FAKE_RSHIFT = 8'h59;

    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_P     = 8'h4D;
    localparam logic [7:0] KEY_R     = 8'h2D;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    // Bytes that follow E1 before the Pause sequence is complete
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } state_t;

    // Keyboard command responses and error codes, never key events
    function automatic logic is_ignored(input logic [7:0] b);
        case (b)
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFF, 8'h00: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] held_mask(input logic [7:0] code, input logic ext);
        logic [7:0] m;
        m = '0;
        if (!ext) begin
            case (code)
                KEY_ESC: m[0] = 1'b1;
                KEY_S:   m[1] = 1'b1;
                KEY_P:   m[2] = 1'b1;
                KEY_R:   m[3] = 1'b1;
                default: m    = '0;
            endcase
        end else begin
            case (code)
                KEY_UP:    m[4] = 1'b1;
                KEY_DOWN:  m[5] = 1'b1;
                KEY_LEFT:  m[6] = 1'b1;
                KEY_RIGHT: m[7] = 1'b1;
                default:   m    = '0;
            endcase
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_scancode_decoder_if.sv
`default_nettype none
// ============================================================================
// Interface : ps2_scancode_decoder_if
// Purpose   : Byte input, event handshake and status bundle of the decoder.
// Revision  : 1.0
// ============================================================================
interface ps2_scancode_decoder_if;
    import ps2_pkg::*;

    logic [7:0]      byte_in;
    logic            byte_valid;
    logic [EV_W-1:0] ev_data;
    logic            ev_valid;
    logic            ev_ready;
    logic [7:0]      held;
    logic            overflow;
    logic            ovf_clr;

    modport master (
        output byte_in, byte_valid, ev_ready, ovf_clr,
        input  ev_data, ev_valid, held, overflow
    );

    modport slave (
        input  byte_in, byte_valid, ev_ready, ovf_clr,
        output ev_data, ev_valid, held, overflow
    );
endinterface
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_event_fifo
// Purpose  : First-word fall-through FIFO; a write into a full FIFO is dropped.
// Revision : 1.0
// ============================================================================
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q, count_q;
    logic             full, pop, push;

    assign empty_o = (count_q == '0);
    assign full    = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    assign pop     = rd_en_i & ~empty_o;
    // A pop in the same cycle frees the slot the write lands in
    assign push    = wr_en_i & (~full | pop);
    assign drop_o  = wr_en_i & full & ~pop;

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scancode_decoder
// Purpose  : Resolves Set-2 prefixes into key events, queues them, tracks held keys.
// Revision : 1.0
// ============================================================================
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ps2_scancode_decoder_if.slave  bus
);
    localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      held_q, held_d;
    logic            ovf_q, ovf_d;

    logic            emit;
    logic [EV_W-1:0] ev_word;
    logic [7:0]      key_mask;
    logic            fifo_empty, fifo_drop;
    logic [EV_W-1:0] fifo_rd;
    logic [7:0]      b;

    assign b = bus.byte_in;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        emit    = 1'b0;
        ev_word = '0;
        if (bus.byte_valid) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (b == PFX_EXT) begin
                        state_d = ST_EXT;
                    end else if (b == PFX_BRK) begin
                        state_d = ST_BRK;
                    end else if (b == PFX_PAUSE) begin
                        state_d = ST_PAUSE;
                        cnt_d   = PAUSE_TAIL;
                    end else if (!is_ignored(b)) begin
                        emit    = 1'b1;
                        ev_word = {2'b00, b};
                    end
                end
                ST_EXT: begin
                    if (b == PFX_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                        // E0 12 / E0 59 are the keyboard's synthetic shift codes
                        if (b != FAKE_LSHIFT && b != FAKE_RSHIFT) begin
                            emit    = 1'b1;
                            ev_word = {2'b01, b};
                        end
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    emit    = 1'b1;
                    ev_word = {2'b10, b};
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                    if (b != FAKE_LSHIFT && b != FAKE_RSHIFT) begin
                        emit    = 1'b1;
                        ev_word = {2'b11, b};
                    end
                end
                ST_PAUSE: begin
                    if (cnt_q == 3'd1) begin
                        state_d = ST_IDLE;
                        emit    = 1'b1;
                        ev_word = {2'b01, PFX_PAUSE};
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // Held flags follow decoded events even when the FIFO drops them
    always_comb begin
        key_mask = held_mask(ev_word[7:0], ev_word[EV_EXT]);
        held_d   = held_q;
        if (emit) begin
            held_d = ev_word[EV_BRK] ? (held_q & ~key_mask) : (held_q | key_mask);
        end
        ovf_d = (ovf_q & ~bus.ovf_clr) | fifo_drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            held_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            held_q  <= held_d;
            ovf_q   <= ovf_d;
        end
    end

    ps2_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (emit),
        .wr_data_i (ev_word),
        .rd_en_i   (bus.ev_ready),
        .rd_data_o (fifo_rd),
        .empty_o   (fifo_empty),
        .drop_o    (fifo_drop)
    );

    assign bus.ev_valid = ~fifo_empty;
    assign bus.ev_data  = fifo_rd;
    assign bus.held     = held_q;
    assign bus.overflow = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ps2_scancode_decoder
// Purpose  : Scoreboard bench: prefix-string reference model, decoupled event monitor.
// Revision : 1.0
// ============================================================================
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 8;
    localparam int TMO   = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_scancode_decoder_if bus();

    ps2_scancode_decoder #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_ev    = 0;
    logic [9:0]  last_ev = '0;
    logic [9:0]  sb[$];
    logic [7:0]  pend[$];
    logic [7:0]  exp_held = '0;
    logic        exp_ovf  = 1'b0;
    longint      cyc      = 0;
    longint      last_cyc = 0;
    bit          rand_ready  = 1'b0;
    logic        ready_force = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        bus.ev_ready = rand_ready ? ($urandom_range(3) != 0) : ready_force;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted event must be the oldest expected one
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ev_valid && bus.ev_ready) begin
                n_ev++;
                last_ev = bus.ev_data;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ev_unexpected: got %0h expected none at %0t", bus.ev_data, $time);
                end else begin
                    check("ev_data", 32'(bus.ev_data), 32'(sb.pop_front()));
                end
            end else if (!bus.ev_valid) begin
                check("ev_data_idle", 32'(bus.ev_data), 32'd0);
            end
        end
    end

    function automatic int key_bit(input logic [7:0] c, input logic e);
        case ({e, c})
            9'h076: return 0;
            9'h01B: return 1;
            9'h04D: return 2;
            9'h02D: return 3;
            9'h175: return 4;
            9'h172: return 5;
            9'h16B: return 6;
            9'h174: return 7;
            default: return -1;
        endcase
    endfunction

    // Reference model: the bytes seen since the last completed event decide the outcome
    task automatic model_byte(input logic [7:0] b, output bit emit, output logic [9:0] ev);
        bit ext, brk;
        emit = 1'b0;
        ev   = '0;
        if (pend.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) pend.push_back(b);
            else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFF, 8'h00})) begin
                emit = 1'b1;
                ev   = {2'b00, b};
            end
        end else if (pend[0] == 8'hE1) begin
            pend.push_back(b);
            if (pend.size() == 8) begin
                emit = 1'b1;
                ev   = 10'h1E1;
                pend.delete();
            end
        end else if (pend.size() == 1 && pend[0] == 8'hE0 && b == 8'hF0) begin
            pend.push_back(b);
        end else begin
            ext = (pend[0] == 8'hE0);
            brk = (pend[pend.size()-1] == 8'hF0);
            pend.delete();
            if (!(ext && (b == 8'h12 || b == 8'h59))) begin
                emit = 1'b1;
                ev   = {brk, ext, b};
            end
        end
    endtask

    // Entered and left at posedge+1; the write edge has passed on return
    task automatic send(input logic [7:0] b);
        bit         emit;
        logic [9:0] ev;
        int         kb;
        logic [7:0] nh;
        logic       nov;
        if (pend.size() != 0 && (cyc - last_cyc - 1) >= TMO) pend.delete();
        last_cyc       = cyc;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        model_byte(b, emit, ev);
        nh  = exp_held;
        nov = exp_ovf;
        if (emit) begin
            kb = key_bit(ev[7:0], ev[8]);
            if (kb >= 0) nh[kb] = ~ev[9];
        end
        @(negedge clk); #1;
        if (emit) begin
            if (sb.size() >= DEPTH) nov = 1'b1;
            else sb.push_back(ev);
        end
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
        exp_held = nh;
        exp_ovf  = nov;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_held"}, 32'(bus.held), 32'(exp_held));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
    endtask

    task automatic clr_ovf();
        bus.ovf_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovf_clr = 1'b0;
        exp_ovf = 1'b0;
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while (sb.size() != 0 && i < 500) begin @(posedge clk); #1; i++; end
        idle(2);
        check({tag, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        pend.delete();
        exp_held = '0;
        exp_ovf  = 1'b0;
    endtask

    logic [7:0] pool [17] = '{8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'h76, 8'h1B, 8'h4D,
                              8'h2D, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h12, 8'h59, 8'h1C, 8'h00};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev0;
        logic [7:0] b;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        bus.ovf_clr    = 1'b0;
        do_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(bus.ev_valid), 32'd0);
        check("rst_data", 32'(bus.ev_data), 32'd0);
        check("rst_held", 32'(bus.held), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: make then break, latency
        ready_force = 1'b1;
        send(8'h1C);
        @(negedge clk);
        check("t1_make_valid", 32'(bus.ev_valid), 32'd1);
        @(posedge clk); #1;
        send(8'hF0); send(8'h1C);
        @(negedge clk);
        check("t1_brk_valid", 32'(bus.ev_valid), 32'd1);
        check("t1_brk_data", 32'(bus.ev_data), 32'h21C);
        @(posedge clk); #1;
        drain("t1");

        // 2: extended UP arrow make/break
        send(8'hE0); send(8'h75);
        check("t2_up_set", 32'(bus.held), 32'h10);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("t2_up_clr", 32'(bus.held), 32'h00);
        drain("t2");
        check("t2_last", 32'(last_ev), 32'h375);

        // 3: Pause yields one event; FA ignored
        ev0 = n_ev;
        foreach (pool[i]) if (i < 0) ev0 = 0;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'hFA);
        drain("t3");
        check("t3_count", 32'(n_ev - ev0), 32'd1);
        check("t3_last", 32'(last_ev), 32'h1E1);

        // 4: overflow with consumer stalled
        ready_force = 1'b0;
        idle(2);
        for (int k = 0; k < 9; k++) send(8'h16 + 8'(k));
        check_status("t4_full");
        check("t4_ovf", 32'(bus.overflow), 32'd1);
        ev0 = n_ev;
        ready_force = 1'b1;
        drain("t4");
        check("t4_count", 32'(n_ev - ev0), 32'd8);
        check("t4_last", 32'(last_ev), 32'h01D);
        clr_ovf();
        check("t4_ovf_clr", 32'(bus.overflow), 32'd0);
        send(8'hF0); send(8'h1B);
        drain("t4b");

        // 5: prefix timeout, fake shifts
        send(8'hF0);
        idle(TMO + 2);
        send(8'h1C);
        drain("t5");
        check("t5_make", 32'(last_ev), 32'h01C);
        ev0 = n_ev;
        send(8'hE0); send(8'h12); send(8'hE0); send(8'hF0); send(8'h12);
        idle(5);
        check("t5_fake", 32'(n_ev - ev0), 32'd0);

        // 6: async reset mid-sequence with events queued
        ready_force = 1'b0;
        idle(2);
        send(8'h1C); send(8'h2D); send(8'h3C);
        send(8'hE0); send(8'hF0);
        check_status("t6_pre");
        check("t6_pre_valid", 32'(bus.ev_valid), 32'd1);
        #2;
        do_reset();
        #1;
        check("t6_valid", 32'(bus.ev_valid), 32'd0);
        check("t6_held", 32'(bus.held), 32'd0);
        check("t6_ovf", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        ready_force = 1'b1;
        send(8'h6B);
        drain("t6");
        check("t6_after", 32'(last_ev), 32'h06B);

        // Random traffic against the model
        rand_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(9) < 3) b = 8'($urandom_range(255));
            else b = pool[$urandom_range(16)];
            send(b);
            check_status("rnd");
            if ($urandom_range(40) == 0) clr_ovf();
            if ($urandom_range(25) == 0) idle(TMO + 5);
            else idle($urandom_range(2));
        end
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        idle(2);
        drain("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
